// File: rtl/rv_wb_arb.sv
// Writeback arbiter: merges single-cycle ALU results with a load-return FIFO onto one RF write port.
// Optional RF read forwarding is built when RV_WB_FWD_EN is defined.
module rv_wb_arb #(
   parameter int unsigned LQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_vld_i,
   output logic        alu_rdy_o,
   input  logic [4:0]  alu_rd_i,
   input  logic [63:0] alu_data_i,
   input  logic        ld_vld_i,
   output logic        ld_rdy_o,
   input  logic [4:0]  ld_rd_i,
   input  logic [2:0]  ld_funct3_i,
   input  logic [2:0]  ld_off_i,
   input  logic [63:0] ld_data_i,
   output logic        wr_en_o,
   output logic [4:0]  wr_reg_o,
   output logic [63:0] wr_data_o,
`ifdef RV_WB_FWD_EN
   input  logic [4:0]  rd_reg1_i,
   input  logic [4:0]  rd_reg2_i,
   output logic        fwd1_vld_o,
   output logic        fwd2_vld_o,
   output logic [63:0] fwd1_data_o,
   output logic [63:0] fwd2_data_o,
`endif
   output logic        ld_err_o
);

   localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
   localparam int unsigned CW = $clog2(LQ_DEPTH + 1);

   typedef struct packed {
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [2:0]  off;
      logic [63:0] data;
   } lq_ent_t;

   lq_ent_t        mem_q [LQ_DEPTH];
   lq_ent_t        head;
   logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           full, alu_xfer, ld_xfer, deq;
   logic           wr_en_q, wr_en_d, ld_err_q, ld_err_d;
   logic [4:0]     wr_reg_q, wr_reg_d;
   logic [63:0]    wr_data_q, wr_data_d;
   logic [63:0]    sh_b, sh_h, sh_w, ld_val;

   // Readiness depends only on the registered count, never on the valids.
   assign full      = (count_q == CW'(LQ_DEPTH));
   assign ld_rdy_o  = !full;
   assign alu_rdy_o = !full;
   assign alu_xfer  = alu_vld_i && !full;
   assign ld_xfer   = ld_vld_i && !full;
   assign deq       = (count_q != '0) && !alu_xfer;
   assign head      = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (ld_xfer) mem_q[wptr_q] <= {ld_rd_i, ld_funct3_i, ld_off_i, ld_data_i};
   end

   // Load alignment and sign/zero extension of the FIFO head.
   always_comb begin
      sh_b = head.data >> {head.off, 3'b000};
      sh_h = head.data >> {head.off[2:1], 4'b0000};
      sh_w = head.data >> {head.off[2], 5'b00000};
      case (head.funct3)
         3'b000:  ld_val = {{56{sh_b[7]}}, sh_b[7:0]};
         3'b001:  ld_val = {{48{sh_h[15]}}, sh_h[15:0]};
         3'b010:  ld_val = {{32{sh_w[31]}}, sh_w[31:0]};
         3'b011:  ld_val = head.data;
         3'b100:  ld_val = {56'd0, sh_b[7:0]};
         3'b101:  ld_val = {48'd0, sh_h[15:0]};
         3'b110:  ld_val = {32'd0, sh_w[31:0]};
         default: ld_val = '0;
      endcase
   end

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      wr_en_d   = 1'b0;
      ld_err_d  = 1'b0;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      if (ld_xfer) wptr_d = wptr_q + PW'(1);
      if (deq)     rptr_d = rptr_q + PW'(1);
      if (ld_xfer && !deq)      count_d = count_q + CW'(1);
      else if (!ld_xfer && deq) count_d = count_q - CW'(1);
      if (alu_xfer) begin
         wr_en_d   = (alu_rd_i != 5'd0);
         wr_reg_d  = alu_rd_i;
         wr_data_d = alu_data_i;
      end else if (deq) begin
         wr_reg_d = head.rd;
         if (head.funct3 == 3'b111) begin
            ld_err_d  = 1'b1;
            wr_data_d = '0;
         end else begin
            wr_en_d   = (head.rd != 5'd0);
            wr_data_d = ld_val;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         ld_err_q  <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         ld_err_q  <= ld_err_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en_o   = wr_en_q;
   assign ld_err_o  = ld_err_q;
   assign wr_reg_o  = wr_reg_q;
   assign wr_data_o = wr_data_q;

`ifdef RV_WB_FWD_EN
   logic        fwd1_vld_q, fwd1_vld_d, fwd2_vld_q, fwd2_vld_d;
   logic [63:0] fwd1_data_q, fwd1_data_d, fwd2_data_q, fwd2_data_d;

   // Bypass for an RF read that samples on the same edge the write lands.
   always_comb begin
      fwd1_vld_d  = wr_en_d && (wr_reg_d == rd_reg1_i) && (rd_reg1_i != 5'd0);
      fwd2_vld_d  = wr_en_d && (wr_reg_d == rd_reg2_i) && (rd_reg2_i != 5'd0);
      fwd1_data_d = wr_data_d;
      fwd2_data_d = wr_data_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd1_vld_q  <= 1'b0;
         fwd2_vld_q  <= 1'b0;
         fwd1_data_q <= '0;
         fwd2_data_q <= '0;
      end else begin
         fwd1_vld_q  <= fwd1_vld_d;
         fwd2_vld_q  <= fwd2_vld_d;
         fwd1_data_q <= fwd1_data_d;
         fwd2_data_q <= fwd2_data_d;
      end
   end

   assign fwd1_vld_o  = fwd1_vld_q;
   assign fwd2_vld_o  = fwd2_vld_q;
   assign fwd1_data_o = fwd1_data_q;
   assign fwd2_data_o = fwd2_data_q;
`endif

endmodule

// File: tb/tb_rv_wb_arb.sv
// Self-checking bench for rv_wb_arb against a queue-based writeback model.
module tb_rv_wb_arb;
   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_vld_i, alu_rdy_o, ld_vld_i, ld_rdy_o;
   logic [4:0]  alu_rd_i, ld_rd_i, wr_reg_o;
   logic [63:0] alu_data_i, ld_data_i, wr_data_o;
   logic [2:0]  ld_funct3_i, ld_off_i;
   logic        wr_en_o, ld_err_o;
`ifdef RV_WB_FWD_EN
   logic [4:0]  rd_reg1_i, rd_reg2_i;
   logic        fwd1_vld_o, fwd2_vld_o;
   logic [63:0] fwd1_data_o, fwd2_data_o;
   logic        exp_f1v, exp_f2v;
   logic [63:0] exp_fd;
`endif

   rv_wb_arb #(.LQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_vld_i(alu_vld_i), .alu_rdy_o(alu_rdy_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
      .ld_vld_i(ld_vld_i), .ld_rdy_o(ld_rdy_o), .ld_rd_i(ld_rd_i), .ld_funct3_i(ld_funct3_i),
      .ld_off_i(ld_off_i), .ld_data_i(ld_data_i),
      .wr_en_o(wr_en_o), .wr_reg_o(wr_reg_o), .wr_data_o(wr_data_o),
`ifdef RV_WB_FWD_EN
      .rd_reg1_i(rd_reg1_i), .rd_reg2_i(rd_reg2_i),
      .fwd1_vld_o(fwd1_vld_o), .fwd2_vld_o(fwd2_vld_o),
      .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o),
`endif
      .ld_err_o(ld_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [2:0]  off;
      logic [63:0] data;
   } ent_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   ent_t        mq[$];
   logic        exp_en, exp_err, exp_rdy;
   logic [4:0]  exp_reg;
   logic [63:0] exp_data;
   logic [70:0] obs_v, exp_v;

   function automatic logic [63:0] extract(input ent_t e);
      logic signed [63:0] s;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      int sh;
      case (e.f3)
         3'd0, 3'd4: begin
            sh = int'(e.off) * 8;
            b = e.data[sh +: 8];
            s = $signed(b);
            return (e.f3 == 3'd0) ? 64'(s) : {56'd0, b};
         end
         3'd1, 3'd5: begin
            sh = (int'(e.off) / 2) * 16;
            h = e.data[sh +: 16];
            s = $signed(h);
            return (e.f3 == 3'd1) ? 64'(s) : {48'd0, h};
         end
         3'd2, 3'd6: begin
            sh = (int'(e.off) / 4) * 32;
            w = e.data[sh +: 32];
            s = $signed(w);
            return (e.f3 == 3'd2) ? 64'(s) : {32'd0, w};
         end
         default: return e.data;
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      exp_en = 1'b0; exp_err = 1'b0; exp_reg = '0; exp_data = '0; exp_rdy = 1'b1;
   endtask

   // Present inputs for the coming edge; readiness expectation from queue occupancy.
   task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                        input logic lv, input ent_t le);
      alu_vld_i = av; alu_rd_i = ard; alu_data_i = ad;
      ld_vld_i = lv; ld_rd_i = le.rd; ld_funct3_i = le.f3; ld_off_i = le.off; ld_data_i = le.data;
      exp_rdy = (mq.size() < DEPTH);
      #1;
   endtask

   // Apply the arbitration rules to the driven inputs, then advance one clock.
   task automatic tick();
      ent_t h, n;
      logic full;
      full = (mq.size() == DEPTH);
      exp_en = 1'b0; exp_err = 1'b0;
      if (alu_vld_i && !full) begin
         exp_en = (alu_rd_i != 0); exp_reg = alu_rd_i; exp_data = alu_data_i;
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         exp_reg = h.rd;
         if (h.f3 == 3'd7) exp_err = 1'b1;
         else begin
            exp_en = (h.rd != 0); exp_data = extract(h);
         end
      end
      if (ld_vld_i && !full) begin
         n.rd = ld_rd_i; n.f3 = ld_funct3_i; n.off = ld_off_i; n.data = ld_data_i;
         mq.push_back(n);
      end
`ifdef RV_WB_FWD_EN
      exp_f1v = exp_en && (exp_reg == rd_reg1_i) && (rd_reg1_i != 0);
      exp_f2v = exp_en && (exp_reg == rd_reg2_i) && (rd_reg2_i != 0);
      exp_fd  = exp_data;
`endif
      @(posedge clk);
      #1;
      obs_v = {wr_en_o, ld_err_o, wr_en_o ? {wr_reg_o, wr_data_o} : 69'd0};
      exp_v = {exp_en, exp_err, exp_en ? {exp_reg, exp_data} : 69'd0};
   endtask

   function automatic ent_t mk(input logic [4:0] rd, input logic [2:0] f3,
                               input logic [2:0] off, input logic [63:0] d);
      ent_t e;
      e.rd = rd; e.f3 = f3; e.off = off; e.data = d;
      return e;
   endfunction

   task automatic test_reset();
      ent_t z;
      z = mk(0, 0, 0, 0);
      rst = 1'b1;
      drive(0, 0, 0, 0, z);
`ifdef RV_WB_FWD_EN
      rd_reg1_i = 0; rd_reg2_i = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({wr_en_o, ld_err_o, wr_reg_o, wr_data_o} !== 71'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en=%0b err=%0b reg=%0d data=%h want all 0",
                  wr_en_o, ld_err_o, wr_reg_o, wr_data_o);
      end
      rst = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({alu_rdy_o, ld_rdy_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_rdy: got alu_rdy=%0b ld_rdy=%0b want 1 1", alu_rdy_o, ld_rdy_o);
      end
   endtask

   task automatic test_alu();
      ent_t z;
      z = mk(0, 0, 0, 0);
      drive(1, 5, 64'h1234, 0, z);
      tick();
      n_tests++;
      if ({wr_en_o, wr_reg_o, wr_data_o} !== {1'b1, 5'd5, 64'h1234}) begin
         n_fail++;
         $display("FAIL alu_write: got en=%0b reg=%0d data=%h want 1 5 1234", wr_en_o, wr_reg_o, wr_data_o);
      end
      drive(0, 0, 0, 0, z);
      tick();
      n_tests++;
      if (wr_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_idle: got en=%0b want 0", wr_en_o);
      end
   endtask

   task automatic test_lb();
      ent_t z;
      logic [63:0] want [2];
      z = mk(0, 0, 0, 0);
      want[0] = 64'hFFFF_FFFF_FFFF_FF80;
      want[1] = 64'h80;
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, mk(3, (i == 0) ? 3'd0 : 3'd4, 3'd3, 64'h0000_0000_8000_0000));
         tick();
         n_tests++;
         if (wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_enqueue_no_write: got en=%0b want 0", wr_en_o);
         end
         drive(0, 0, 0, 0, z);
         tick();
         n_tests++;
         if ({wr_en_o, wr_reg_o, wr_data_o} !== {1'b1, 5'd3, want[i]}) begin
            n_fail++;
            $display("FAIL lb_extract%0d: got en=%0b reg=%0d data=%h want 1 3 %h",
                     i, wr_en_o, wr_reg_o, wr_data_o, want[i]);
         end
      end
   endtask

   task automatic test_fill();
      ent_t z;
      int nld, nstall;
      logic [4:0] order [$];
      z = mk(0, 0, 0, 0);
      nld = 0; nstall = 0;
      for (int c = 0; c < 14; c++) begin
         if (c < 10) drive(1, 20, 64'(c), (nld < 3), mk(5'(10 + nld), 3'd3, 0, 64'(100 + nld)));
         else        drive(0, 0, 0, 0, z);
         n_tests++;
         if ({alu_rdy_o, ld_rdy_o} !== {exp_rdy, exp_rdy}) begin
            n_fail++;
            $display("FAIL fill_rdy c%0d: got alu=%0b ld=%0b want %0b", c, alu_rdy_o, ld_rdy_o, exp_rdy);
         end
         if (alu_vld_i && !alu_rdy_o) nstall++;
         if (ld_vld_i && exp_rdy) nld++;
         tick();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL fill_out c%0d: got %h want %h", c, obs_v, exp_v);
         end
         if (wr_en_o && wr_reg_o >= 10 && wr_reg_o <= 12) order.push_back(wr_reg_o);
      end
      n_tests++;
      if (nstall == 0 || order.size() != 3 || order[0] != 10 || order[1] != 11 || order[2] != 12) begin
         n_fail++;
         $display("FAIL fill_order: got stalls=%0d loads=%0d want stalls>0 loads 10,11,12 in order",
                  nstall, order.size());
      end
   endtask

   task automatic test_err();
      ent_t z;
      int nerr, nwr;
      z = mk(0, 0, 0, 0);
      nerr = 0; nwr = 0;
      for (int c = 0; c < 6; c++) begin
         if (c == 0)      drive(0, 0, 0, 1, mk(0, 3'd3, 0, 64'hDEAD));
         else if (c == 1) drive(0, 0, 0, 1, mk(9, 3'd7, 0, 64'hBEEF));
         else             drive(0, 0, 0, 0, z);
         tick();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL err_out c%0d: got %h want %h", c, obs_v, exp_v);
         end
         nerr += int'(ld_err_o);
         nwr  += int'(wr_en_o);
      end
      n_tests++;
      if (nerr != 1 || nwr != 0 || ld_rdy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_summary: got err_pulses=%0d writes=%0d ld_rdy=%0b want 1 0 1", nerr, nwr, ld_rdy_o);
      end
   endtask

   task automatic test_reset_mid();
      ent_t z;
      z = mk(0, 0, 0, 0);
      for (int c = 0; c < 2; c++) begin
         drive(1, 20, 64'hA0, 1, mk(5'(14 + c), 3'd3, 0, 64'h55));
         tick();
      end
      drive(1, 21, 64'hA1, 0, z);
      tick();
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({wr_en_o, ld_err_o, wr_reg_o, wr_data_o, ld_rdy_o} !== {71'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL midreset_async: got en=%0b err=%0b reg=%0d data=%h ld_rdy=%0b want 0 0 0 0 1",
                  wr_en_o, ld_err_o, wr_reg_o, wr_data_o, ld_rdy_o);
      end
      drive(0, 0, 0, 0, z);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         drive(0, 0, 0, 0, z);
         tick();
         n_tests++;
         if (wr_en_o !== 1'b0 || obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL midreset_drain c%0d: got en=%0b reg=%0d want no write", c, wr_en_o, wr_reg_o);
         end
      end
   endtask

`ifdef RV_WB_FWD_EN
   task automatic test_fwd();
      ent_t z;
      z = mk(0, 0, 0, 0);
      rd_reg1_i = 7; rd_reg2_i = 0;
      drive(1, 7, 64'hAA, 0, z);
      tick();
      n_tests++;
      if ({fwd1_vld_o, fwd1_data_o, fwd2_vld_o} !== {1'b1, 64'hAA, 1'b0}) begin
         n_fail++;
         $display("FAIL fwd_basic: got v1=%0b d1=%h v2=%0b want 1 aa 0", fwd1_vld_o, fwd1_data_o, fwd2_vld_o);
      end
   endtask
`endif

   task automatic test_random();
      ent_t e;
      logic [4:0] ard;
      for (int c = 0; c < 400; c++) begin
         e.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         e.f3   = 3'($urandom_range(0, 7));
         e.off  = 3'($urandom_range(0, 7));
         e.data = {$urandom, $urandom};
         ard    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
`ifdef RV_WB_FWD_EN
         rd_reg1_i = 5'($urandom_range(0, 31));
         rd_reg2_i = ($urandom_range(0, 1) == 0) ? ard : 5'($urandom_range(0, 31));
`endif
         drive(($urandom_range(0, 1) == 1), ard, {$urandom, $urandom}, ($urandom_range(0, 4) < 3), e);
         n_tests++;
         if ({alu_rdy_o, ld_rdy_o} !== {exp_rdy, exp_rdy}) begin
            n_fail++;
            $display("FAIL rand_rdy c%0d: got alu=%0b ld=%0b want %0b", c, alu_rdy_o, ld_rdy_o, exp_rdy);
         end
         tick();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL rand_out c%0d: got %h want %h", c, obs_v, exp_v);
         end
`ifdef RV_WB_FWD_EN
         n_tests++;
         if ({fwd1_vld_o, fwd2_vld_o} !== {exp_f1v, exp_f2v} ||
             (exp_f1v && fwd1_data_o !== exp_fd) || (exp_f2v && fwd2_data_o !== exp_fd)) begin
            n_fail++;
            $display("FAIL rand_fwd c%0d: got v=%0b%0b d1=%h d2=%h want v=%0b%0b d=%h",
                     c, fwd1_vld_o, fwd2_vld_o, fwd1_data_o, fwd2_data_o, exp_f1v, exp_f2v, exp_fd);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb();
      test_fill();
      test_err();
      test_reset_mid();
`ifdef RV_WB_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rv_wb_arb.md
RV_WB_ARB -- requirements
Module: rv_wb_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in (rising edge), rst in (asynchronous, active-high).
REQ-002 The parameter LQ_DEPTH SHALL default to 2 and set the number of load-return FIFO entries (power of two, 2..8).
REQ-003 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  async active-high reset
- alu_vld_i  in  1  ALU result valid
- alu_rdy_o  out  1  ALU result accepted this cycle
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  64  ALU result
- ld_vld_i  in  1  load return valid
- ld_rdy_o  out  1  load FIFO not full
- ld_rd_i  in  5  load destination register
- ld_funct3_i  in  3  load type (RV64 funct3)
- ld_off_i  in  3  byte offset in the doubleword
- ld_data_i  in  64  raw aligned doubleword
- wr_en_o  out  1  register-file write enable
- wr_reg_o  out  5  register-file write index
- wr_data_o  out  64  register-file write data
- ld_err_o  out  1  one-cycle pulse on illegal load funct3
- rd_reg1_i, rd_reg2_i  in  5  RF read indices (RV_WB_FWD_EN only)
- fwd1_vld_o, fwd2_vld_o  out  1  forward hit (RV_WB_FWD_EN only)
- fwd1_data_o, fwd2_data_o  out  64  forwarded data (RV_WB_FWD_EN only)

Function
REQ-004 A transfer SHALL occur on a rising edge when both vld and rdy are high; ld_rdy_o = (count < LQ_DEPTH), computed without a combinational path from ld_vld_i.
REQ-005 A load transfer SHALL enqueue {rd, funct3, off, data} into the FIFO; the FIFO SHALL use wrapping read/write pointers and a 0..LQ_DEPTH count.
REQ-006 Arbitration per cycle: if the FIFO is full, the FIFO head SHALL win and alu_rdy_o = 0; otherwise alu_rdy_o = 1 and an ALU transfer wins; the FIFO head SHALL be dequeued only in cycles with no ALU transfer.
REQ-007 The winner SHALL be registered onto wr_en_o/wr_reg_o/wr_data_o; ALU latency = 1 clock; load latency ≥ 2 clocks (enqueue, then dequeue).
REQ-008 wr_en_o SHALL be 0 when the winner's rd = 0, but the entry SHALL still be consumed.
REQ-009 Load extraction: LB/LBU take the byte at off; LH/LHU take the half at off[2:1]; LW/LWU take the word at off[2]; LD takes all 64 bits; B/H/W sign-extend and BU/HU/WU zero-extend; unused low off bits are ignored.
REQ-010 funct3 = 111 SHALL dequeue without a write (wr_en_o = 0) and pulse ld_err_o for one cycle, aligned with the slot the write would occupy.
REQ-011 Simultaneous enqueue and dequeue with the FIFO full SHALL be impossible by construction (ld_rdy_o = 0); with count unchanged otherwise.
REQ-012 The block SHALL NOT reorder writes to the same rd beyond the REQ-006 order; upstream guarantees no WAW between pending loads and ALU results.

Reset
REQ-013 While rst = 1 (asynchronous): wr_en_o = 0, wr_reg_o = 0, wr_data_o = 0, ld_err_o = 0, pointers/count = 0, fwd*_vld_o = 0, fwd*_data_o = 0; ld_rdy_o = 1 and alu_rdy_o = 1 after release.
REQ-014 Reset mid-operation SHALL discard all FIFO entries and any in-flight write; no write SHALL issue in the first cycle after release.

Configuration
REQ-015 With RV_WB_FWD_EN defined: fwdN_vld_o SHALL be registered as (wr_en_o-next && wr_reg-next == rd_regN_i && rd_regN_i != 0), with fwdN_data_o = the write data, covering an RF read issued on the same edge as the write.
REQ-016 Without RV_WB_FWD_EN: the rd_reg*/fwd* ports SHALL be absent and the related logic removed; all other behaviour SHALL be identical.

Verification
REQ-017 ALU only: alu_vld_i = 1, rd = 5, data = 0x1234 -> one clock later wr_en_o = 1, wr_reg_o = 5, wr_data_o = 0x1234.
REQ-018 LB: off = 3, data = 0x00000000_80000000 -> wr_data_o = 0xFFFFFFFF_FFFFFF80; same with LBU -> 0x80.
REQ-019 Continuous ALU traffic plus 3 loads -> FIFO fills, ld_rdy_o = 0, alu_rdy_o = 0 for one cycle while the head drains; all loads are written in order.
REQ-020 Load with rd = 0, then funct3 = 111 -> no wr_en_o for either, ld_err_o pulses once, count returns to 0.
REQ-021 Assert rst with 2 loads queued -> outputs 0 immediately, no queued write after release.
REQ-022 (RV_WB_FWD_EN) Write x7 = 0xAA while rd_reg1_i = 7 -> fwd1_vld_o = 1, fwd1_data_o = 0xAA; rd_reg2_i = 0 -> fwd2_vld_o = 0.
